cdb_arbiter: RTL and testbench

Round-robin arbiter for the common data bus (CDB) that writes back into the tagged register file and the reservation stations. Functional units (ALU, branch, load/store, mul) each present a completed result (tag + data). The arbiter grants at most one per cycle and drives a registered CDB broadcast. The broadcast is consumed by the register file, which matches the tag against busy entries, and by the reservation stations.

---
 rtl/cdb_arbiter.sv | 90 +++++++++
 tb/tb_cdb_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: round-robin grant among functional-unit results,
// registered single-cycle CDB broadcast and a saturating busy-cycle counter.
module cdb_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned SRC_W   = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic                       cdb_valid,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [WIDTH-1:0]           cdb_data,
  output logic [SRC_W-1:0]           cdb_src,
  output logic [31:0]                cdb_busy_cnt
);

  localparam logic [TAG_W-1:0] INVALID_TAG = {1'b1, {(TAG_W-1){1'b0}}};

  logic [SRC_W-1:0]   rr_ptr;
  logic [TAG_W-1:0]   tag_arr  [NUM_REQ];
  logic [WIDTH-1:0]   data_arr [NUM_REQ];

  logic [NUM_REQ-1:0] grant_vec;
  logic               grant_any;
  logic [SRC_W-1:0]   grant_idx;
  logic [SRC_W-1:0]   next_ptr;
  logic [TAG_W-1:0]   grant_tag;
  logic [WIDTH-1:0]   grant_data;
  logic               grant_bcast;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign tag_arr[g]  = req_tag[g*TAG_W +: TAG_W];
    assign data_arr[g] = req_data[g*WIDTH +: WIDTH];
  end

  // Walk offsets from rr_ptr; the first valid unit wins. rst/flush suppress all grants.
  always_comb begin
    logic [SRC_W-1:0] sel;
    sel        = '0;
    grant_vec  = '0;
    grant_any  = 1'b0;
    grant_idx  = '0;
    if (!rst && !flush) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        sel = SRC_W'((32'(rr_ptr) + k) % NUM_REQ);
        if (!grant_any && req_valid[sel]) begin
          grant_any      = 1'b1;
          grant_idx      = sel;
          grant_vec[sel] = 1'b1;
        end
      end
    end
  end

  assign grant_tag   = tag_arr[grant_idx];
  assign grant_data  = data_arr[grant_idx];
  assign next_ptr    = SRC_W'((32'(grant_idx) + 32'd1) % NUM_REQ);
  assign grant_bcast = grant_any && (grant_tag != INVALID_TAG);
  assign req_ready   = grant_vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr       <= '0;
      cdb_valid    <= 1'b0;
      cdb_tag      <= INVALID_TAG;
      cdb_data     <= '0;
      cdb_src      <= '0;
      cdb_busy_cnt <= '0;
    end else begin
      if (grant_any)
        rr_ptr <= next_ptr;
      // Invalid-tag results are consumed but dropped; payload holds when not broadcasting.
      cdb_valid <= grant_bcast;
      if (grant_bcast) begin
        cdb_tag  <= grant_tag;
        cdb_data <= grant_data;
        cdb_src  <= grant_idx;
      end
      if (cdb_valid && (cdb_busy_cnt != '1))
        cdb_busy_cnt <= cdb_busy_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed requests per unit, expected
// broadcasts queued in order, a negedge monitor pops and compares.
module tb_cdb_arbiter;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_tag;
  logic [127:0] req_data;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [1:0]  cdb_src;
  logic [31:0] cdb_busy_cnt;

  cdb_arbiter #(.NUM_REQ(4), .WIDTH(32), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_tag(req_tag), .req_data(req_data),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_src(cdb_src), .cdb_busy_cnt(cdb_busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] data;
    logic [1:0]  src;
  } exp_t;

  exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  logic [3:0]  ptag  [4][8];
  logic [31:0] pdata [4][8];
  int unsigned head [4];
  int unsigned tail [4];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (head[i] != tail[i]) begin
        req_valid[i]       = 1'b1;
        req_tag[i*4 +: 4]  = ptag[i][head[i]];
        req_data[i*32 +: 32] = pdata[i][head[i]];
      end else begin
        req_valid[i]       = 1'b0;
        req_tag[i*4 +: 4]  = '0;
        req_data[i*32 +: 32] = '0;
      end
    end
  endtask

  task automatic add(int unsigned u, logic [3:0] t, logic [31:0] d);
    ptag[u][tail[u]]  = t;
    pdata[u][tail[u]] = d;
    tail[u]++;
    drive();
  endtask

  task automatic expect_bc(logic [3:0] t, logic [31:0] d, logic [1:0] s);
    exp_t e;
    e.tag = t; e.data = d; e.src = s;
    exp_q.push_back(e);
  endtask

  // One clock: accept what was granted, retire those entries, re-drive.
  task automatic step();
    logic [3:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (acc[i]) head[i]++;
    drive();
    #1;
  endtask

  // Monitor: every broadcast must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst && cdb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_bcast_tag", {60'd0, cdb_tag}, 64'hFFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("bcast_tag",  {60'd0, cdb_tag},  {60'd0, e.tag});
        chk("bcast_data", {32'd0, cdb_data}, {32'd0, e.data});
        chk("bcast_src",  {62'd0, cdb_src},  {62'd0, e.src});
      end
    end
  end

  // Units hold valid/tag/data stable until accepted.
  logic [3:0]  p_v = '0;
  logic [3:0]  p_r = '0;
  logic [15:0] p_tag = '0;
  logic [127:0] p_data = '0;
  logic        p_gate = 1'b0;
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (p_gate && p_v[i] && !p_r[i])
        assert (req_valid[i] && req_tag[i*4 +: 4] == p_tag[i*4 +: 4] &&
                req_data[i*32 +: 32] == p_data[i*32 +: 32])
          else $error("handshake not held for unit %0d", i);
    p_v    <= req_valid;
    p_r    <= req_ready;
    p_tag  <= req_tag;
    p_data <= req_data;
    p_gate <= !rst && !flush;
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    rst   = 1'b1;
    flush = 1'b0;
    drive();
    step();
    step();
    rst = 1'b0;

    // Reset then idle
    for (int c = 0; c < 5; c++) begin
      step();
      chk("idle_valid", {63'd0, cdb_valid}, 64'd0);
      chk("idle_ready", {60'd0, req_ready}, 64'd0);
    end
    chk("rst_tag",  {60'd0, cdb_tag},  64'h8);
    chk("rst_data", {32'd0, cdb_data}, 64'd0);
    chk("rst_src",  {62'd0, cdb_src},  64'd0);
    chk("rst_busy", {32'd0, cdb_busy_cnt}, 64'd0);

    // Single requester
    add(2, 4'd3, 32'hDEADBEEF);
    expect_bc(4'd3, 32'hDEADBEEF, 2'd2);
    #1;
    chk("single_ready", {60'd0, req_ready}, 64'b0100);
    step();
    chk("single_valid", {63'd0, cdb_valid}, 64'd1);
    chk("single_data",  {32'd0, cdb_data}, 64'hDEADBEEF);
    step();
    chk("single_valid_off", {63'd0, cdb_valid}, 64'd0);
    chk("single_busy", {32'd0, cdb_busy_cnt}, 64'd1);

    // Round-robin fairness from reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rr_rst_busy", {32'd0, cdb_busy_cnt}, 64'd0);
    for (int k = 0; k < 2; k++)
      for (int u = 0; u < 4; u++) begin
        add(u, 4'(u), 32'h1000 + 32'(16*u + k));
        expect_bc(4'(u), 32'h1000 + 32'(16*u + k), 2'(u));
      end
    #1;
    chk("rr_first_ready", {60'd0, req_ready}, 64'b0001);
    for (int c = 0; c < 8; c++) begin
      step();
      chk("rr_valid", {63'd0, cdb_valid}, 64'd1);
    end
    step();
    chk("rr_valid_off", {63'd0, cdb_valid}, 64'd0);
    chk("rr_busy", {32'd0, cdb_busy_cnt}, 64'd8);

    // Invalid tag: consumed, not broadcast, pointer still advances
    add(1, 4'b1000, 32'h11111111);
    add(3, 4'd5, 32'h55555555);
    expect_bc(4'd5, 32'h55555555, 2'd3);
    #1;
    chk("inv_ready1", {60'd0, req_ready}, 64'b0010);
    step();
    chk("inv_valid", {63'd0, cdb_valid}, 64'd0);
    chk("inv_tag_hold", {60'd0, cdb_tag}, 64'd3);
    chk("inv_ready3", {60'd0, req_ready}, 64'b1000);
    step();
    chk("inv_next_valid", {63'd0, cdb_valid}, 64'd1);
    step();
    chk("inv_busy", {32'd0, cdb_busy_cnt}, 64'd9);

    // Flush after unit 0's grant
    add(0, 4'hA, 32'hA0A0A0A0);
    add(1, 4'hB, 32'hB0B0B0B0);
    expect_bc(4'hA, 32'hA0A0A0A0, 2'd0);
    expect_bc(4'hB, 32'hB0B0B0B0, 2'd1);
    #1;
    chk("fl_ready0", {60'd0, req_ready}, 64'b0001);
    step();
    flush = 1'b1;
    #1;
    chk("fl_ready_off", {60'd0, req_ready}, 64'd0);
    chk("fl_bcast_kept", {63'd0, cdb_valid}, 64'd1);
    step();
    flush = 1'b0;
    #1;
    chk("fl_after_valid", {63'd0, cdb_valid}, 64'd0);
    chk("fl_ready1", {60'd0, req_ready}, 64'b0010);
    step();
    chk("fl_unit1_valid", {63'd0, cdb_valid}, 64'd1);
    step();
    chk("fl_busy", {32'd0, cdb_busy_cnt}, 64'd11);

    // Reset in the cycle unit 2 would be granted
    for (int u = 0; u < 4; u++)
      add(u, 4'(u + 1), 32'h5000 + 32'(u));
    #1;
    chk("mr_ready2", {60'd0, req_ready}, 64'b0100);
    rst = 1'b1;
    #1;
    chk("mr_ready_rst", {60'd0, req_ready}, 64'd0);
    step();
    rst = 1'b0;
    for (int u = 0; u < 4; u++)
      expect_bc(4'(u + 1), 32'h5000 + 32'(u), 2'(u));
    #1;
    chk("mr_valid", {63'd0, cdb_valid}, 64'd0);
    chk("mr_tag", {60'd0, cdb_tag}, 64'h8);
    chk("mr_busy", {32'd0, cdb_busy_cnt}, 64'd0);
    chk("mr_ready0", {60'd0, req_ready}, 64'b0001);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("mr_burst_valid", {63'd0, cdb_valid}, 64'd1);
    end
    step();
    chk("mr_busy_end", {32'd0, cdb_busy_cnt}, 64'd4);
    step();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
